// File: rtl/pri_enc16_4.sv
// Sequential 16-to-4 priority encoder: captures request pulses into a pending
// register and offers one pending index at a time over a valid/ack handshake.
module pri_enc16_4 #(
  parameter bit RR_MODE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        ack,
  output logic [3:0]  code_out,
  output logic        valid,
  output logic [15:0] pending_out,
  output logic        any_pending
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pending, pend_nxt, clr;
  logic [3:0]  code, code_nxt;
  logic [3:0]  ptr, ptr_nxt;
  logic [3:0]  start, win;
  logic        accept, win_found;

  assign accept = (state == OFFER) && ack;

  // A bit re-requested in the same cycle it is acknowledged stays pending.
  always_comb begin
    clr      = '0;
    if (accept) clr[code] = 1'b1;
    pend_nxt = (pending & ~clr) | req;
  end

  // Round-robin searches from one past the code being retired this cycle, so
  // back-to-back grants rotate even before the pointer register catches up.
  always_comb begin
    start = 4'd0;
    if (RR_MODE) start = accept ? (code + 4'd1) : ptr;
  end

  always_comb begin
    logic [3:0] idx;
    win       = 4'd0;
    win_found = 1'b0;
    idx       = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = start + 4'(i);
      if (!win_found && pend_nxt[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (en && win_found) begin
          code_nxt  = win;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (ack) begin
          ptr_nxt = code + 4'd1;
          if (en && win_found) begin
            code_nxt = win;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      code    <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pend_nxt;
      code    <= code_nxt;
      ptr     <= ptr_nxt;
    end
  end

  assign code_out    = code;
  assign valid       = (state == OFFER);
  assign pending_out = pending;
  assign any_pending = |pending;

endmodule

// File: tb/tb_pri_enc16_4.sv
// Bench for pri_enc16_4: fixed-priority and round-robin instances side by side,
// checked against directed tables and a behavioural model under random stimulus.
module tb_pri_enc16_4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] req = '0;
  logic        ack = 1'b0;

  logic [3:0]  code_fix, code_rr;
  logic        valid_fix, valid_rr;
  logic [15:0] pend_fix, pend_rr;
  logic        any_fix, any_rr;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  pri_enc16_4 #(.RR_MODE(1'b0)) u_fix (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .code_out(code_fix), .valid(valid_fix),
    .pending_out(pend_fix), .any_pending(any_fix)
  );

  pri_enc16_4 #(.RR_MODE(1'b1)) u_rr (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .code_out(code_rr), .valid(valid_rr),
    .pending_out(pend_rr), .any_pending(any_rr)
  );

  // Reference model, index 0 = fixed priority, index 1 = round-robin.
  logic [15:0] mPend[2];
  logic [3:0]  mCode[2];
  logic [3:0]  mPtr[2];
  logic        mValid[2];

  function automatic logic [3:0] pick(input logic [15:0] p, input int from);
    for (int k = 0; k < 16; k++) begin
      int j;
      j = (from + k) % 16;
      if (p[j]) return 4'(j);
    end
    return 4'd0;
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      mPend[m] = '0; mCode[m] = '0; mPtr[m] = '0; mValid[m] = 1'b0;
    end
  endtask

  task automatic modelStep();
    for (int m = 0; m < 2; m++) begin
      logic        took;
      logic [15:0] np;
      int          from;
      took = mValid[m] && ack;
      np   = mPend[m];
      if (took) np[mCode[m]] = 1'b0;
      np   = np | req;
      from = 0;
      if (m == 1) from = took ? (int'(mCode[m]) + 1) % 16 : int'(mPtr[m]);
      if (took) mPtr[m] = 4'((int'(mCode[m]) + 1) % 16);
      if (!mValid[m] || took) begin
        if (en && np != 16'h0) begin
          mValid[m] = 1'b1;
          mCode[m]  = pick(np, from);
        end else begin
          mValid[m] = 1'b0;
        end
      end
      mPend[m] = np;
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkModel();
    checkOutput("fix.valid", 16'(valid_fix), 16'(mValid[0]));
    checkOutput("fix.pend",  pend_fix, mPend[0]);
    checkOutput("fix.any",   16'(any_fix), 16'(mPend[0] != 16'h0));
    if (mValid[0]) checkOutput("fix.code", 16'(code_fix), 16'(mCode[0]));
    checkOutput("rr.valid",  16'(valid_rr), 16'(mValid[1]));
    checkOutput("rr.pend",   pend_rr, mPend[1]);
    checkOutput("rr.any",    16'(any_rr), 16'(mPend[1] != 16'h0));
    if (mValid[1]) checkOutput("rr.code", 16'(code_rr), 16'(mCode[1]));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, sample 1 ns later.
  task automatic applyStimulus(input logic e, input logic [15:0] r, input logic a);
    en = e; req = r; ack = a;
    @(posedge clk);
    if (rst) modelReset(); else modelStep();
    #1;
  endtask

  task automatic doReset();
    en = 1'b0; req = '0; ack = 1'b0;
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst.fix.valid", 16'(valid_fix), 16'h0);
    checkOutput("rst.fix.code",  16'(code_fix), 16'h0);
    checkOutput("rst.fix.pend",  pend_fix, 16'h0);
    checkOutput("rst.fix.any",   16'(any_fix), 16'h0);
    checkOutput("rst.rr.valid",  16'(valid_rr), 16'h0);
    checkOutput("rst.rr.code",   16'(code_rr), 16'h0);
  endtask

  typedef struct {
    logic        en;
    logic [15:0] req;
    logic        ack;
    logic        expValid;
    logic [3:0]  expCode;
    logic [15:0] expPend;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Fixed-priority directed sequence, expectations are after each edge.
    tbl[0]  = '{1'b1, 16'h0020, 1'b0, 1'b1, 4'd5,  16'h0020};
    tbl[1]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 4'd5,  16'h0000};
    tbl[2]  = '{1'b1, 16'h8421, 1'b1, 1'b1, 4'd0,  16'h8421};
    tbl[3]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 4'd5,  16'h8420};
    tbl[4]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 4'd10, 16'h8400};
    tbl[5]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 4'd15, 16'h8000};
    tbl[6]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 4'd15, 16'h0000};
    tbl[7]  = '{1'b0, 16'h0100, 1'b0, 1'b0, 4'd15, 16'h0100};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd15, 16'h0100};
    tbl[9]  = '{1'b1, 16'h0000, 1'b0, 1'b1, 4'd8,  16'h0100};
    tbl[10] = '{1'b1, 16'h0000, 1'b1, 1'b0, 4'd8,  16'h0000};
    tbl[11] = '{1'b1, 16'h0008, 1'b0, 1'b1, 4'd3,  16'h0008};
    tbl[12] = '{1'b1, 16'h0008, 1'b1, 1'b1, 4'd3,  16'h0008};
    tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd3,  16'h0008};
    tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd3,  16'h0008};
    tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd3,  16'h0000};
    tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd3,  16'h0000};

    $display("[TB] reset and directed fixed-priority table");
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].en, tbl[i].req, tbl[i].ack);
      checkOutput($sformatf("tbl%0d.valid", i), 16'(valid_fix), 16'(tbl[i].expValid));
      checkOutput($sformatf("tbl%0d.code", i),  16'(code_fix), 16'(tbl[i].expCode));
      checkOutput($sformatf("tbl%0d.pend", i),  pend_fix, tbl[i].expPend);
      checkOutput($sformatf("tbl%0d.any", i),   16'(any_fix), 16'(tbl[i].expPend != 16'h0));
      checkModel();
    end

    $display("[TB] reset mid-offer");
    doReset();
    applyStimulus(1'b1, 16'h0480, 1'b0);
    checkOutput("mid.valid", 16'(valid_fix), 16'h1);
    checkOutput("mid.code",  16'(code_fix), 16'd7);
    checkOutput("mid.pend",  pend_fix, 16'h0480);
    req = '0;
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkOutput("midrst.valid", 16'(valid_fix), 16'h0);
    checkOutput("midrst.code",  16'(code_fix), 16'h0);
    checkOutput("midrst.pend",  pend_fix, 16'h0);
    checkOutput("midrst.any",   16'(any_fix), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'h0000, 1'b1);
      checkOutput("postrst.valid", 16'(valid_fix), 16'h0);
      checkOutput("postrst.pend",  pend_fix, 16'h0);
      checkModel();
    end

    $display("[TB] round-robin alternation");
    doReset();
    applyStimulus(1'b1, 16'h0011, 1'b0);
    checkOutput("rr0.valid", 16'(valid_rr), 16'h1);
    checkOutput("rr0.code",  16'(code_rr), 16'd0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 16'h0011, 1'b1);
      checkOutput($sformatf("rr%0d.valid", i), 16'(valid_rr), 16'h1);
      checkOutput($sformatf("rr%0d.code", i),  16'(code_rr), (i % 2 == 1) ? 16'd4 : 16'd0);
      checkOutput($sformatf("rr%0d.pend", i),  pend_rr, 16'h0011);
      checkOutput($sformatf("rrfix%0d.code", i), 16'(code_fix), 16'd0);
      checkModel();
    end

    $display("[TB] random stimulus against model");
    doReset();
    for (int i = 0; i < 400; i++) begin
      logic [15:0] r;
      r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      applyStimulus($urandom_range(0, 3) != 0, r, 1'($urandom_range(0, 1)));
      checkModel();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/pri_enc16_4.md
Name: pri_enc16_4

Overview:
- Sequential 16-to-4 priority encoder with request capture and a valid/ack handshake. It is the encode-side counterpart of the team's 4-to-16 decoder.
- It collects request pulses on 16 lines into a pending register. It presents one pending index at a time as a 4-bit code and clears that bit when the consumer acknowledges.
- Used where many event lines must be serialised onto a 4-bit index bus, e.g. feeding the 4-to-16 decoder at the far end.

Parameters:
- RR_MODE, 0, arbitration policy. 0 = fixed priority (lowest index wins); 1 = round-robin starting from (last granted index + 1), wrapping 15->0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  offer enable; when low, no new offer starts, but request capture continues.
- req  input  16  request lines; any cycle with req[i]=1 sets pending bit i.
- ack  input  1  consumer accepts the current code; meaningful only while valid=1.
- code_out  output  4  encoded index of the offered request; stable while valid=1.
- valid  output  1  code_out holds an offer.
- pending_out  output  16  current pending register contents (registered).
- any_pending  output  1  OR-reduction of pending_out.

Behaviour:
- Reset: asynchronous, active-high. While rst=1 and on its release:
  - pending=16'h0000, code_out=4'h0, valid=0
  - state=IDLE, round-robin pointer=0
  - any_pending=0
- Reset mid-offer aborts the offer with no clear or ack side effects.
- Pending update each edge: pending <= (pending & ~clr) | req.
  - clr is the one-hot of code_out when valid & ack, else 0.
  - If req[i]=1 in the same cycle bit i is cleared by ack, the bit stays set (new event wins).
- Winner selection: combinational over the next-state pending value (after clear and new req).
  - RR_MODE=0: lowest set index.
  - RR_MODE=1: first set index searching upward from ptr, wrapping mod 16.
- FSM states: IDLE, OFFER.
  - IDLE, en=1, next-pending nonzero: load code_out=winner, valid<=1, go OFFER. Pointer unchanged until ack.
  - IDLE, otherwise: stay; valid=0; code_out holds its last value.
  - OFFER, ack=0: hold code_out and valid=1 regardless of en or req. An offer is never withdrawn or re-prioritised.
  - OFFER, ack=1, en=1, next-pending nonzero: load the next winner into code_out, keep valid=1, stay OFFER. This gives back-to-back, one code per cycle.
  - OFFER, ack=1, otherwise: valid<=0, go IDLE.
  - On every ack: ptr <= code_out+1 (4-bit wrap, 15->0). Pointer is only used when RR_MODE=1.
- Latency: req pulse in cycle N → pending bit visible after edge N. If IDLE with en=1, valid=1 with that code in the same edge, i.e. code available cycle N+1.
- ack while valid=0 is ignored; it has no effect on pending or ptr.
- Arithmetic: code_out is exactly 4 bits; the index is the bit position within req/pending.
- any_pending and pending_out reflect the register only, not same-cycle req.

Test Plan:
- Reset: assert rst mid-offer (valid=1, code 7, pending 0x0480) → same cycle pending=0, valid=0, code_out=0. After release with req=0, everything stays idle.
- Single event: RR_MODE=0, en=1, pulse req=0x0020 in cycle N → cycle N+1 valid=1, code_out=5, pending_out=0x0020. Ack in N+1 → cycle N+2 valid=0, pending_out=0, any_pending=0.
- Burst, fixed priority: req=0x8421 for one cycle, ack held high → codes 0,5,10,15 on four consecutive cycles with valid continuous, then valid=0 and pending=0.
- Round-robin: RR_MODE=1, req=0x0011 held high, ack every cycle → code sequence 0,4,0,4,…; pending_out stays 0x0011.
- Enable gating: en=0, pulse req=0x0100 → valid stays 0, pending_out=0x0100, any_pending=1. Raise en → next cycle valid=1, code_out=8.
- Re-request collision: RR_MODE=0, offer code 3 pending, ack and req=0x0008 in the same cycle → bit 3 stays pending, valid stays 1, code_out=3 again next cycle. Dropping ack with en=0 holds the offer unchanged.
